rom_dn_sequencer: RTL and testbench

- Sits between the HPS download interface and the arcade core's dn_addr/dn_data/dn_wr ports.
- Filters the ROM download stream (ioctl_index 0) and registers it one cycle.
- Checks that the stream is sequential and complete.
- Holds the core in reset until a valid image is present, and flags short or out-of-order images so the core never runs from a partial ROM set.

---
 rtl/rom_dn_pkg.sv | 19 +
 rtl/dn_edge_det.sv | 21 ++
 rtl/rom_dn_sequencer.sv | 155 +++++++++++++++
 tb/tb_rom_dn_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dn_pkg.sv
// Shared types and defaults for the ROM download sequencer.
package rom_dn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    SETTLE,
    RUN,
    FAIL
  } state_t;

  // Exact byte count of a complete ROM image.
  localparam logic [18:0] DEF_EXPECTED_LEN = 19'h1C200;

  // ioctl_index slot carrying the ROM image.
  localparam logic [7:0] DEF_ROM_INDEX = 8'd0;

endpackage

// File: rtl/dn_edge_det.sv
// Rise/fall detector for ioctl_download against its value on the previous clock.
module dn_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;

  // Remember the previous level of the download flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule

// File: rtl/rom_dn_sequencer.sv
// ROM download sequencer: forwards the index-0 download stream to the core
// one cycle late, checks it is sequential and complete, and holds the core in
// reset until a valid image is present.
// Optional: define ROM_DN_CHECKSUM_EN to add a 16-bit byte-sum check (rom_sum).
module rom_dn_sequencer
  import rom_dn_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 19,
  parameter logic [7:0]        ROM_INDEX     = DEF_ROM_INDEX,
  parameter logic [ADDR_W-1:0] EXPECTED_LEN  = ADDR_W'(DEF_EXPECTED_LEN),
  parameter int unsigned       SETTLE_CYCLES = 16
`ifdef ROM_DN_CHECKSUM_EN
  ,
  parameter logic [15:0]       EXPECTED_SUM  = 16'h0000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              core_reset,
  output logic              rom_ready,
  output logic              rom_error,
  output logic [ADDR_W:0]   byte_count
`ifdef ROM_DN_CHECKSUM_EN
  ,
  output logic [15:0]       rom_sum
`endif
);

  localparam int unsigned SC_W = $clog2(SETTLE_CYCLES + 1);

  state_t            state_q, state_d;
  logic              dl_rise, dl_fall;
  logic              rom_sel_q;
  logic              idx_match, rom_eff, start, accept, fwd, seq_bad, image_ok;
  logic              err_seq_q, err_base;
  logic [ADDR_W:0]   cnt_base;
  logic [SC_W-1:0]   settle_q;

  dn_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (ioctl_download),
    .rise  (dl_rise),
    .fall  (dl_fall)
  );

  // ROM-ness is decided at the download rising edge and held for the transfer;
  // during the rising-edge cycle itself the live index is used so a byte
  // arriving together with the rise is not lost.
  assign idx_match = (ioctl_index == ROM_INDEX);
  assign rom_eff   = dl_rise ? idx_match : rom_sel_q;
  assign start     = dl_rise & idx_match & (state_q != LOAD);
  assign accept    = ioctl_download & ioctl_wr & rom_eff & (start | (state_q == LOAD));

  // A new load clears count/error in the same cycle a first byte may land.
  assign cnt_base  = start ? '0 : byte_count;
  assign err_base  = start ? 1'b0 : err_seq_q;
  assign seq_bad   = (ioctl_addr != 25'(cnt_base)) | (ioctl_addr[24:ADDR_W] != '0);
  assign fwd       = accept & (ioctl_addr < 25'(EXPECTED_LEN));

`ifdef ROM_DN_CHECKSUM_EN
  logic [15:0] sum_q;

  // Wrapping sum of every accepted byte of the current load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sum_q <= '0;
    else if (accept) sum_q <= (start ? 16'h0000 : sum_q) + {8'h00, ioctl_dout};
    else if (start)  sum_q <= '0;
  end

  assign rom_sum  = sum_q;
  assign image_ok = (byte_count == (ADDR_W+1)'(EXPECTED_LEN)) & ~err_seq_q & (sum_q == EXPECTED_SUM);
`else
  assign image_ok = (byte_count == (ADDR_W+1)'(EXPECTED_LEN)) & ~err_seq_q;
`endif

  // Latch whether the current download is the ROM slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rom_sel_q <= 1'b0;
    else if (dl_rise) rom_sel_q <= idx_match;
  end

  // Registered forward of accepted in-range bytes to the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dn_wr   <= 1'b0;
      dn_addr <= '0;
      dn_data <= '0;
    end else begin
      dn_wr <= fwd;
      if (fwd) begin
        dn_addr <= ioctl_addr[ADDR_W-1:0];
        dn_data <= ioctl_dout;
      end
    end
  end

  // Saturating byte counter and sticky sequence-error flag for the load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_count <= '0;
      err_seq_q  <= 1'b0;
    end else if (accept) begin
      byte_count <= (cnt_base == '1) ? cnt_base : cnt_base + (ADDR_W+1)'(1);
      err_seq_q  <= err_base | seq_bad;
    end else if (start) begin
      byte_count <= '0;
      err_seq_q  <= 1'b0;
    end
  end

  // Settle counter runs only while in SETTLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 settle_q <= '0;
    else if (state_q == SETTLE) settle_q <= settle_q + SC_W'(1);
    else                       settle_q <= '0;
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      core_reset <= 1'b1;
      rom_ready  <= 1'b0;
      rom_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_reset <= (state_d != RUN);
      rom_ready  <= (state_d == RUN);
      rom_error  <= (state_d == FAIL);
    end
  end

  // Next-state logic; a new ROM download restarts the load from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN, FAIL: state_d = state_q;
      LOAD:            if (dl_fall) state_d = CHECK;
      CHECK:           state_d = image_ok ? SETTLE : FAIL;
      SETTLE:          if (settle_q == SC_W'(SETTLE_CYCLES - 1)) state_d = RUN;
      default:         state_d = IDLE;
    endcase
    if (start) state_d = LOAD;
  end

endmodule

// File: tb/tb_rom_dn_sequencer.sv
// Self-checking bench for rom_dn_sequencer with a behavioural reference model.
// Uses a shortened image length to keep runtime small.
module tb_rom_dn_sequencer;

  localparam logic [18:0] LEN    = 19'h200;
  localparam int          SETTLE = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [18:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset, rom_ready, rom_error;
  logic [19:0] byte_count;
`ifdef ROM_DN_CHECKSUM_EN
  logic [15:0] rom_sum;
`endif

  rom_dn_sequencer #(
    .ADDR_W        (19),
    .ROM_INDEX     (8'd0),
    .EXPECTED_LEN  (LEN),
    .SETTLE_CYCLES (SETTLE)
`ifdef ROM_DN_CHECKSUM_EN
    ,
    .EXPECTED_SUM  (16'h1234)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .core_reset     (core_reset),
    .rom_ready      (rom_ready),
    .rom_error      (rom_error),
    .byte_count     (byte_count)
`ifdef ROM_DN_CHECKSUM_EN
    ,
    .rom_sum        (rom_sum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int total_pulses = 0;
  logic [7:0] img [0:1023];

  // Behavioural model state (expected outputs after each rising edge).
  bit          m_prev, m_rom, m_loading, m_bad, m_pend;
  int          m_cnt;
  int          m_settle = -1;
  logic [15:0] m_sum;
  bit          e_wr, e_cr = 1'b1, e_rdy, e_err;
  logic [18:0] e_addr;
  logic [7:0]  e_data;

  always @(posedge clk or posedge reset) begin : model
    bit rise, fall, good;
    if (reset) begin
      m_prev = 0; m_rom = 0; m_loading = 0; m_bad = 0; m_pend = 0;
      m_cnt = 0; m_settle = -1; m_sum = 0;
      e_wr = 0; e_addr = '0; e_data = '0; e_cr = 1; e_rdy = 0; e_err = 0;
    end else begin
      rise   = ioctl_download && !m_prev;
      fall   = !ioctl_download && m_prev;
      m_prev = ioctl_download;
      if (rise) m_rom = (ioctl_index == 8'd0);
      e_wr = 0;
      if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) begin e_rdy = 1; e_cr = 0; m_settle = -1; end
      end
      if (m_pend) begin
        m_pend = 0;
        good = (m_cnt == int'(LEN)) && !m_bad;
`ifdef ROM_DN_CHECKSUM_EN
        good = good && (m_sum == 16'h1234);
`endif
        if (good) m_settle = SETTLE;
        else      e_err = 1;
      end
      if (rise && m_rom && !m_loading) begin
        m_loading = 1; m_cnt = 0; m_bad = 0; m_sum = 0; m_pend = 0; m_settle = -1;
        e_rdy = 0; e_err = 0; e_cr = 1;
      end
      if (m_loading && ioctl_download && ioctl_wr && m_rom) begin
        if (int'(ioctl_addr) != m_cnt || ioctl_addr >= 25'h80000) m_bad = 1;
        if (m_cnt < 20'hFFFFF) m_cnt++;
        m_sum = m_sum + 16'(ioctl_dout);
        if (ioctl_addr < 25'(LEN)) begin
          e_wr = 1; e_addr = ioctl_addr[18:0]; e_data = ioctl_dout;
        end
      end
      if (fall && m_loading) begin m_loading = 0; m_pend = 1; end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (dn_wr === 1'b1) total_pulses++;
        check("dn_wr", 32'(dn_wr), 32'(e_wr));
        if (e_wr) begin
          check("dn_addr", 32'(dn_addr), 32'(e_addr));
          check("dn_data", 32'(dn_data), 32'(e_data));
        end
        check("core_reset", 32'(core_reset), 32'(e_cr));
        check("rom_ready", 32'(rom_ready), 32'(e_rdy));
        check("rom_error", 32'(rom_error), 32'(e_err));
        check("byte_count", 32'(byte_count), 32'(m_cnt));
`ifdef ROM_DN_CHECKSUM_EN
        check("rom_sum", 32'(rom_sum), 32'(m_sum));
`endif
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dn_wr"}, 32'(dn_wr), 0);
    check({tag, "_dn_addr"}, 32'(dn_addr), 0);
    check({tag, "_dn_data"}, 32'(dn_data), 0);
    check({tag, "_core_reset"}, 32'(core_reset), 1);
    check({tag, "_rom_ready"}, 32'(rom_ready), 0);
    check({tag, "_rom_error"}, 32'(rom_error), 0);
    check({tag, "_byte_count"}, 32'(byte_count), 0);
  endtask

  // Drive one download of n strobes; 'skip' drops one address, 'abort_at'
  // fires an asynchronous reset mid-load, idx2 replaces the index after the rise.
  task automatic do_load(input logic [7:0] idx, input int n, input int skip,
                         input int abort_at, input logic [7:0] idx2);
    int a;
    a = 0;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    step((idx2 != idx) ? 1 + $urandom_range(0, 2) : $urandom_range(0, 2));
    ioctl_index = idx2;
    for (int i = 0; i < n; i++) begin
      if (i == skip) a++;
      if (i == abort_at) begin
        #3 reset = 1'b1;
        #1 check_reset_values("async_rst");
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
        return;
      end
      ioctl_addr = 25'(a);
      ioctl_dout = img[a];
      ioctl_wr   = 1'b1;
      step(1);
      ioctl_wr = 1'b0;
      if ($urandom_range(0, 1) == 0) step($urandom_range(1, 3));
      a++;
    end
    step($urandom_range(1, 2));
    ioctl_download = 1'b0;
  endtask

  // Count rising edges from the download fall until core_reset drops.
  task automatic measure_release(output int edges);
    edges = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (core_reset === 1'b0) return;
    end
    edges = -1;
  endtask

  task automatic fill_img(input int mode);
    for (int i = 0; i < 1024; i++) begin
      if (mode == 0) img[i] = 8'(i);
      else           img[i] = 8'($urandom);
    end
  endtask

  initial begin
    int edges, p0;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    reset = 1'b0;
    step(2);

    // Full sequential load with data = addr[7:0].
    fill_img(0);
    p0 = total_pulses;
    do_load(8'd0, int'(LEN), -1, -1, 8'd0);
    measure_release(edges);
    check("settle_edges", edges, 18);
    step(2);
    check("full_pulses", total_pulses - p0, 512);
    check("full_ready", 32'(rom_ready), 1);
    check("full_error", 32'(rom_error), 0);

    // Non-ROM slot download while running.
    fill_img(1);
    p0 = total_pulses;
    do_load(8'd254, 8, -1, -1, 8'd254);
    step(5);
    check("dip_pulses", total_pulses - p0, 0);
    check("dip_ready", 32'(rom_ready), 1);
    check("dip_core_reset", 32'(core_reset), 0);

    // Short image.
    do_load(8'd0, int'(LEN) - 1, -1, -1, 8'd0);
    step(25);
    check("short_error", 32'(rom_error), 1);
    check("short_ready", 32'(rom_ready), 0);
    check("short_core_reset", 32'(core_reset), 1);

    // Address skip after 0xFF: in-range bytes still forwarded.
    p0 = total_pulses;
    do_load(8'd0, int'(LEN), 256, -1, 8'd0);
    step(25);
    check("skip_pulses", total_pulses - p0, 511);
    check("skip_error", 32'(rom_error), 1);

    // Good reload out of FAIL.
    do_load(8'd0, int'(LEN), -1, -1, 8'd0);
    step(25);
    check("reload_ready", 32'(rom_ready), 1);

    // ROM download with zero bytes.
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    step(3);
    ioctl_download = 1'b0;
    step(5);
    check("empty_error", 32'(rom_error), 1);

    // Index switches to 0 mid-transfer: transfer stays non-ROM.
    p0 = total_pulses;
    do_load(8'd254, 8, -1, -1, 8'd0);
    step(5);
    check("idxchg_pulses", total_pulses - p0, 0);
    check("idxchg_error", 32'(rom_error), 1);

    // Async reset mid-load, then a full reload.
    do_load(8'd0, int'(LEN), -1, 9'h100, 8'd0);
    check("post_rst_ready", 32'(rom_ready), 0);
    do_load(8'd0, int'(LEN), -1, -1, 8'd0);
    step(25);
    check("after_rst_ready", 32'(rom_ready), 1);

`ifdef ROM_DN_CHECKSUM_EN
    // Image whose byte sum is exactly 0x1234, then the same with one byte bumped.
    for (int i = 0; i < 1024; i++) img[i] = 8'h00;
    for (int i = 0; i < 18; i++) img[i] = 8'hFF;
    img[18] = 8'h46;
    do_load(8'd0, int'(LEN), -1, -1, 8'd0);
    step(25);
    check("cks_ok_ready", 32'(rom_ready), 1);
    img[100] = 8'h01;
    do_load(8'd0, int'(LEN), -1, -1, 8'd0);
    step(25);
    check("cks_bad_error", 32'(rom_error), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
